// File: rtl/serial_and_pkg.sv
// Shared types for the serial AND receiver: default word width, the
// bit-count type and the receiver state encoding.
package serial_and_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef logic [$clog2(DATA_WIDTH)-1:0] count_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } rx_state_t;

endpackage : serial_and_pkg

// File: rtl/bit_counter.sv
// Modulo-data_width bit position counter. Clear beats load-to-1, which beats
// increment; tc_o flags the last bit position of a word.
module bit_counter
    import serial_and_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH,
    parameter int unsigned count_w    = $clog2(data_width)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               load1_i,
    input  logic               inc_i,
    output logic [count_w-1:0] count_o,
    output logic               tc_o
);

    localparam logic [count_w-1:0] LAST = count_w'(data_width - 1);

    logic [count_w-1:0] count_q;
    logic [count_w-1:0] count_d;

    // NOTE: combinational blocks assign a default first so every path drives
    // the signal and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = count_w'(1);
        end else if (inc_i) begin
            count_d = count_q + count_w'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == LAST);

endmodule : bit_counter

// File: rtl/serial_and_receiver.sv
// Assembles LSB-first AND-ed bit pairs into a data_width-bit word and offers
// it on a valid/ready handshake; in_first resynchronises framing mid-word.
module serial_and_receiver
    import serial_and_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  a_bit,
    input  logic                  b_bit,
    output logic                  in_ready,
    output logic [data_width-1:0] y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err
);

    localparam int unsigned COUNT_W = $clog2(data_width);

    rx_state_t             state_q;
    rx_state_t             state_d;
    logic [data_width-1:0] y_q;
    logic [data_width-1:0] y_d;
    logic                  frame_err_q;
    logic                  frame_err_d;

    logic [COUNT_W-1:0]    count;
    logic                  count_tc;
    logic [COUNT_W-1:0]    bit_idx;
    logic                  in_xfer;
    logic                  word_done;

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign in_xfer   = in_valid & in_ready;

    // A first-flagged pair always lands in bit 0 and can never close a word.
    assign bit_idx   = in_first ? '0 : count;
    assign word_done = in_xfer & ~in_first & count_tc;

    bit_counter #(
        .data_width (data_width),
        .count_w    (COUNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (word_done),
        .load1_i (in_xfer & in_first),
        .inc_i   (in_xfer),
        .count_o (count),
        .tc_o    (count_tc)
    );

    always_comb begin
        y_d = y_q;
        if (in_xfer) begin
            y_d[bit_idx] = a_bit & b_bit;
        end
    end

    assign frame_err_d = in_xfer & in_first & (count != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (word_done) state_d = HOLD;
            HOLD:    if (out_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: y is an ordinary register, not a memory, so it is cleared by the
    // synchronous reset along with the control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            y_q         <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign y         = y_q;
    assign frame_err = frame_err_q;

endmodule : serial_and_receiver

// File: tb/tb_serial_and_receiver.sv
// Directed self-checking bench for serial_and_receiver at data_width = 8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_serial_and_receiver;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_first;
    logic         a_bit;
    logic         b_bit;
    logic         in_ready;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_and_receiver #(.data_width(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted bit pair; caller guarantees the receiver is in COLLECT.
    task automatic send_bit(input logic a, input logic b, input logic first);
        a_bit    = a;
        b_bit    = b;
        in_first = first;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        wa = 8'hF0;
        wb = 8'h3C;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 1'b0);
        // Reset wins over a concurrent valid bit pair.
        reset    = 1'b1;
        in_valid = 1'b1;
        a_bit    = 1'b1;
        b_bit    = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'h00 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got out_valid=%b in_ready=%b y=%h frame_err=%b, want 0 1 00 0",
                     out_valid, in_ready, y, frame_err);
        end
        for (int i = 0; i < W - 1; i++) send_bit(wa[i], wb[i], 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_count_cleared: out_valid=%b after 7 bits, want 0", out_valid);
        end
        send_bit(wa[W-1], wb[W-1], 1'b0);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h30) begin
            errors++;
            $display("FAIL reset_next_word: got out_valid=%b y=%h, want 1 30", out_valid, y);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        wa = 8'hF0;
        wb = 8'h3C;
        out_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            send_bit(wa[i], wb[i], 1'b0);
            if (i < W - 1) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_early_%0d: got out_valid=%b in_ready=%b, want 0 1",
                             i, out_valid, in_ready);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 8'h30) begin
            errors++;
            $display("FAIL basic_word: got out_valid=%b in_ready=%b y=%h, want 1 0 30",
                     out_valid, in_ready, y);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        wa = 8'hFF;
        wb = 8'hA5;
        out_ready = 1'b0;
        for (int i = 0; i < W; i++) send_bit(wa[i], wb[i], 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 8'hA5 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b y=%h frame_err=%b, want 1 0 a5 0",
                         c, out_valid, in_ready, y, frame_err);
            end
            // Pairs offered during HOLD must not be absorbed.
            in_valid = c[0];
            in_first = c[1];
            a_bit    = 1'b0;
            b_bit    = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        wa = 8'h0F;
        wb = 8'h33;
        for (int i = 0; i < W - 1; i++) send_bit(wa[i], wb[i], 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_not_absorbed: out_valid=%b after 7 bits, want 0", out_valid);
        end
        send_bit(wa[W-1], wb[W-1], 1'b0);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h03) begin
            errors++;
            $display("FAIL bp_next_word: got out_valid=%b y=%h, want 1 03", out_valid, y);
        end
        tick();
    endtask

    task automatic test_resync();
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        wa = 8'h0F;
        wb = 8'hFF;
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL resync_no_err_before: frame_err=%b, want 0", frame_err);
        end
        send_bit(wa[0], wb[0], 1'b1);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL resync_pulse: frame_err=%b, want 1", frame_err);
        end
        for (int i = 1; i < W; i++) begin
            send_bit(wa[i], wb[i], 1'b0);
            checks++;
            if (frame_err !== 1'b0) begin
                errors++;
                $display("FAIL resync_pulse_width_%0d: frame_err=%b, want 0", i, frame_err);
            end
        end
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h0F) begin
            errors++;
            $display("FAIL resync_word: got out_valid=%b y=%h, want 1 0f", out_valid, y);
        end
        tick();
    endtask

    task automatic test_gapped();
        logic [W-1:0] wa [2];
        logic [W-1:0] wb [2];
        logic [W-1:0] wy [2];
        int           gaps [16];
        int           err_seen;
        wa = '{8'hAA, 8'h55};
        wb = '{8'hFF, 8'h55};
        wy = '{8'hAA, 8'h55};
        gaps = '{0, 2, 1, 3, 0, 0, 2, 1, 3, 1, 0, 2, 0, 3, 1, 0};
        err_seen = 0;
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < W; i++) begin
                for (int g = 0; g < gaps[w*W+i]; g++) begin
                    tick();
                    if (frame_err !== 1'b0) err_seen++;
                end
                send_bit(wa[w][i], wb[w][i], 1'b0);
                if (frame_err !== 1'b0) err_seen++;
            end
            checks++;
            if (out_valid !== 1'b1 || y !== wy[w]) begin
                errors++;
                $display("FAIL gapped_word_%0d: got out_valid=%b y=%h, want 1 %h", w, out_valid, y, wy[w]);
            end
            tick();
        end
        checks++;
        if (err_seen != 0) begin
            errors++;
            $display("FAIL gapped_frame_err: saw %0d frame_err cycles, want 0", err_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] wa [4];
        logic [W-1:0] wb [4];
        logic [W-1:0] wy [4];
        int           idx;
        int           done;
        int           stalls;
        int           last;
        logic         rdy_before;
        wa = '{8'h12, 8'hC3, 8'hFF, 8'h6E};
        wb = '{8'hFF, 8'h3C, 8'h81, 8'hB7};
        wy = '{8'h12, 8'h00, 8'h81, 8'h26};
        idx = 0;
        done = 0;
        stalls = 0;
        last = 0;
        out_ready = 1'b1;
        in_first  = 1'b0;
        in_valid  = 1'b1;
        a_bit = wa[0][0];
        b_bit = wb[0][0];
        rdy_before = in_ready;
        for (int c = 1; c <= 60 && done < 4; c++) begin
            tick();
            if (rdy_before) idx++;
            if (!in_ready) stalls++;
            if (out_valid) begin
                checks++;
                if (y !== wy[done]) begin
                    errors++;
                    $display("FAIL b2b_word_%0d: got y=%h, want %h", done, y, wy[done]);
                end
                checks++;
                if ((done == 0 && c != 8) || (done > 0 && c - last != 9)) begin
                    errors++;
                    $display("FAIL b2b_period_%0d: out_valid at cycle %0d (previous %0d), want first at 8 then every 9",
                             done, c, last);
                end
                last = c;
                done++;
            end
            if (idx < 4 * W) begin
                a_bit = wa[idx/W][idx%W];
                b_bit = wb[idx/W][idx%W];
            end else begin
                in_valid = 1'b0;
            end
            rdy_before = in_ready;
        end
        in_valid = 1'b0;
        checks++;
        if (done != 4) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d words within 60 cycles, want 4", done);
        end
        checks++;
        if (stalls != 4) begin
            errors++;
            $display("FAIL b2b_stalls: got %0d in_ready-low cycles, want 4", stalls);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_resync();
        test_gapped();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_and_receiver

// File: doc/serial_and_receiver.md
# serial_and_receiver

Receiving end of a bit-serial operand link: accepts two operand bit streams (`a_bit`, `b_bit`) one bit pair per accepted cycle, LSB first. Each bit pair is ANDed and the results are assembled into a `data_width`-bit word `y`. The word is presented on a valid/ready output handshake. Sits between a serial operand source and any parallel consumer of the bitwise-AND result, with the same `data_width` parameterisation as the primitives library.

## Interface
- `data_width`, 8, word width in bits; legal range ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a bit pair is present on `a_bit`/`b_bit`.
- `in_first`  in  1  qualifies the current bit pair as bit 0 of a new word; meaningful only with `in_valid`.
- `a_bit`  in  1  serial operand A bit.
- `b_bit`  in  1  serial operand B bit.
- `in_ready`  out  1  block can accept a bit pair this cycle.
- `y`  out  data_width  assembled word; bit i = a_i & b_i.
- `out_valid`  out  1  `y` holds a complete word.
- `out_ready`  in  1  consumer takes `y` this cycle.
- `frame_err`  out  1  one-cycle pulse when a partial word is discarded.

## Operation
- An input transfer happens when `in_valid & in_ready` in a cycle. An output transfer happens when `out_valid & out_ready` in a cycle.
- State machine, two states:
  - **COLLECT**
    - `in_ready` = 1 and `out_valid` = 0.
    - On each input transfer, write `a_bit & b_bit` into `y[count]` and increment `count`.
    - When the transfer with `count == data_width-1` occurs, go to HOLD with `count` = 0.
  - **HOLD**
    - `in_ready` = 0, `out_valid` = 1, `y` stable.
    - On an output transfer, go to COLLECT.
- `in_first` handling:
  - An input transfer with `in_first` = 1 writes `y[0]` and sets `count` = 1.
  - If `count` ≠ 0 at that moment, the partial word is discarded and `frame_err` pulses for the next cycle.
  - `in_first` with `count` == 0 behaves as a normal bit 0.
- Bits of `y` not yet written in COLLECT are don't-care. Consumers sample `y` only while `out_valid` = 1.
- `in_first` is never required; free-running streams work with count-based framing alone.
- `data_width` == 1 is outside the legal range.

## Timing
- Reset values:
  - state = COLLECT, `count` = 0, `y` = 0.
  - `out_valid` = 0, `in_ready` = 1, `frame_err` = 0.
- Reset has priority over every other input in the same cycle and aborts any partial word or held word; a word held in HOLD is lost.
- Latency:
  - `out_valid` rises in the cycle after the input transfer of bit `data_width-1`.
  - The minimum word period is `data_width` + 1 cycles when `out_ready` is held at 1. There is one bubble cycle, in HOLD, per word.
- `out_valid` falls in the cycle after the output transfer.
- `in_ready` is 1 again in that same cycle; there is no bypass from HOLD to COLLECT within one cycle.
- `in_valid` in HOLD is ignored (no transfer). The upstream source must hold its bit pair until `in_ready`.
- `frame_err` is registered, 1 cycle wide, and coincides with the cycle in which `count` = 1.
- `count` wraps only through the HOLD path; it never exceeds `data_width-1`.

## Structure
- Shared package `serial_and_pkg`:
  - `data_width` default constant.
  - `count_t` = `logic [$clog2(data_width)-1:0]`.
  - State enum `rx_state_t` {COLLECT, HOLD}.
- One sub-module: `bit_counter`, a modulo-`data_width` counter with synchronous clear, load-to-1 (for `in_first`) and increment enable, exposing a terminal-count flag.
- Top-level logic: state register, `y` bit-write decode, `frame_err` register, handshake outputs decoded from state.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-word (`count` = 5) → next cycle `out_valid` = 0, `in_ready` = 1, `y` = 0. A following full word assembles correctly from bit 0.
- **Basic word:** `data_width` = 8, stream a = 0xF0, b = 0x3C LSB first with `in_valid` = 1 and `out_ready` = 1 → `out_valid` for 1 cycle, 1 cycle after the 8th bit, with `y` = 0x30. `in_ready` = 0 during that cycle.
- **Back-pressure:** hold `out_ready` = 0 for 5 cycles after word a = 0xFF, b = 0xA5 → `y` = 0xA5 stable, `out_valid` = 1 and `in_ready` = 0 throughout. `in_valid` pulses during HOLD are not absorbed.
- **Resync:** after 3 bits, present `in_first` = 1 with a new word a = 0x0F, b = 0xFF → `frame_err` pulses once, and the output word is `y` = 0x0F.
- **Gapped input:** random `in_valid` gaps (0–3 idle cycles) across two words a = 0xAA/b = 0xFF then a = 0x55/b = 0x55 → outputs 0xAA then 0x55, no `frame_err`.
- **Back-to-back:** continuous `in_valid`, `out_ready` = 1 for 4 words → exactly one `in_ready` = 0 cycle per word; word period is 9 cycles.
